// File: rtl/dem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dem_pkg : shared constants and helpers for the DEM element selector    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package dem_pkg;

  localparam int DEM_N_DEFAULT  = 6;
  localparam int DEM_CW_DEFAULT = 16;
  localparam int DEM_MAX_N      = 32;
  localparam int DEM_CNT_W      = 6;

  // Thermometer code of x, limited to the lowest n bits.
  function automatic logic [DEM_MAX_N-1:0] therm(input logic [DEM_CNT_W-1:0] x,
                                                 input logic [DEM_CNT_W-1:0] n);
    logic [DEM_MAX_N-1:0] t;
    t = '0;
    for (int i = 0; i < DEM_MAX_N; i++) begin
      t[i] = (DEM_CNT_W'(i) < x) && (DEM_CNT_W'(i) < n);
    end
    return t;
  endfunction

  function automatic logic [DEM_CNT_W-1:0] popcount(input logic [DEM_MAX_N-1:0] x);
    logic [DEM_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < DEM_MAX_N; i++) begin
      c = c + DEM_CNT_W'(x[i]);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dem_pos_dec.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dem_pos_dec : one priority position -> N-bit one-hot element select    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module dem_pos_dec #(
  parameter int N  = 6,
  parameter int IW = $clog2(N)
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  onehot
);

  // Out-of-range indices simply match no element.
  always_comb begin
    onehot = '0;
    for (int e = 0; e < N; e++) begin
      if (en && (int'(idx) == e)) begin
        onehot[e] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dem_sel_n.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dem_sel_n : DEM unit-element selector with usage counters and check    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module dem_sel_n
  import dem_pkg::*;
#(
  parameter int N  = DEM_N_DEFAULT,
  parameter int IW = $clog2(N),
  parameter int CW = DEM_CW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [IW:0]     v,
  input  logic [IW:0]     gama,
  input  logic [IW:0]     beta,
  input  logic [N*IW-1:0] sq,
  input  logic            isi_sel,
  input  logic            mis_sel,
  input  logic            cnt_clr,
  output logic            out_valid,
  output logic [N-1:0]    sv,
  output logic            err,
  output logic [N*CW-1:0] use_cnt
);

  localparam logic [DEM_CNT_W-1:0] N_W = DEM_CNT_W'(N);

  logic [DEM_CNT_W-1:0] v_w;
  logic [DEM_CNT_W-1:0] v_sat;
  logic [DEM_CNT_W-1:0] sel_pop;
  logic [DEM_MAX_N-1:0] therm_full;
  logic [N-1:0]         therm_v;
  logic [N-1:0]         pos_en;
  logic [N-1:0]         sel;
  logic [N-1:0]         pos_oh [N];

  logic [N-1:0]  sv_d, sv_q;
  logic          out_valid_d, out_valid_q;
  logic          err_d, err_q;
  logic [CW-1:0] cnt_d [N];
  logic [CW-1:0] cnt_q [N];

  // Requests above N behave as N for both the code and the check.
  assign v_w        = DEM_CNT_W'(v);
  assign v_sat      = (v_w > N_W) ? N_W : v_w;
  assign therm_full = therm(v_sat, N_W);
  assign therm_v    = therm_full[N-1:0];

  generate
    if (N < DEM_MAX_N) begin : g_unused
      logic unused_therm_hi;
      assign unused_therm_hi = ^therm_full[DEM_MAX_N-1:N];
    end
  endgenerate

  generate
    for (genvar k = 0; k < N; k++) begin : g_pos
      assign pos_en[k] = isi_sel ? therm_v[k]
                                 : ((k < int'(gama)) || ((k + int'(beta)) >= N));

      dem_pos_dec #(
        .N  (N),
        .IW (IW)
      ) u_dec (
        .idx    (sq[k*IW +: IW]),
        .en     (pos_en[k]),
        .onehot (pos_oh[k])
      );
    end
  endgenerate

  always_comb begin
    sel = '0;
    if (mis_sel) begin
      sel = therm_v;
    end else begin
      for (int k = 0; k < N; k++) begin
        sel = sel | pos_oh[k];
      end
    end
  end

  assign sel_pop = popcount(DEM_MAX_N'(sel));

  always_comb begin
    sv_d        = sv_q;
    out_valid_d = in_valid;
    err_d       = err_q;
    for (int e = 0; e < N; e++) begin
      cnt_d[e] = cnt_q[e];
    end

    if (in_valid) begin
      sv_d = sel;
    end

    // A clear wins over the same cycle's counter and error update.
    if (cnt_clr) begin
      err_d = 1'b0;
      for (int e = 0; e < N; e++) begin
        cnt_d[e] = '0;
      end
    end else if (in_valid) begin
      if (!mis_sel && (sel_pop != v_sat)) begin
        err_d = 1'b1;
      end
      for (int e = 0; e < N; e++) begin
        if (sel[e] && (cnt_q[e] != {CW{1'b1}})) begin
          cnt_d[e] = cnt_q[e] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sv_q        <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      for (int e = 0; e < N; e++) begin
        cnt_q[e] <= '0;
      end
    end else begin
      sv_q        <= sv_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      for (int e = 0; e < N; e++) begin
        cnt_q[e] <= cnt_d[e];
      end
    end
  end

  assign sv        = sv_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

  generate
    for (genvar e = 0; e < N; e++) begin : g_cnt_out
      assign use_cnt[e*CW +: CW] = cnt_q[e];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dem_sel_n.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_dem_sel_n : directed and random checks of dem_sel_n (N=6, CW=4)     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_dem_sel_n;

  localparam int N    = 6;
  localparam int IW   = 3;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [IW:0]     v, gama, beta;
  logic [N*IW-1:0] sq;
  logic            isi_sel, mis_sel, cnt_clr;
  logic            out_valid;
  logic [N-1:0]    sv;
  logic            err;
  logic [N*CW-1:0] use_cnt;

  int tests = 0;
  int fails = 0;

  logic [N-1:0] m_sv;
  logic         m_ov;
  logic         m_err;
  int           m_cnt [N];

  dem_sel_n #(.N(N), .IW(IW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .v         (v),
    .gama      (gama),
    .beta      (beta),
    .sq        (sq),
    .isi_sel   (isi_sel),
    .mis_sel   (mis_sel),
    .cnt_clr   (cnt_clr),
    .out_valid (out_valid),
    .sv        (sv),
    .err       (err),
    .use_cnt   (use_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [N*IW-1:0] mk_sq(int a0, int a1, int a2, int a3, int a4, int a5);
    logic [N*IW-1:0] q;
    q = {IW'(a5), IW'(a4), IW'(a3), IW'(a2), IW'(a1), IW'(a0)};
    return q;
  endfunction

  // Selected element set straight from the priority-position rules.
  function automatic logic [N-1:0] ref_sel(int vv, int g, int b, logic [N*IW-1:0] q,
                                           logic isi, logic mis);
    logic [N-1:0] r;
    int vs, idx;
    bit en;
    r  = '0;
    vs = (vv > N) ? N : vv;
    if (mis) begin
      for (int e = 0; e < N; e++) if (e < vs) r[e] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++) begin
      en  = isi ? (k < vs) : ((k < g) || (k >= N - b));
      idx = int'(q[k*IW +: IW]);
      if (en && idx < N) r[idx] = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("sv", 32'(sv), 32'(m_sv));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("err", 32'(err), 32'(m_err));
    for (int e = 0; e < N; e++)
      chk($sformatf("use_cnt%0d", e), 32'(use_cnt[e*CW +: CW]), 32'(m_cnt[e]));
  endtask

  task automatic model_reset();
    m_sv  = '0;
    m_ov  = 1'b0;
    m_err = 1'b0;
    for (int e = 0; e < N; e++) m_cnt[e] = 0;
  endtask

  task automatic step(logic iv, int vv, int g, int b, logic [N*IW-1:0] q,
                      logic isi, logic mis, logic clr, logic rs);
    logic [N-1:0] s;
    int vs;
    in_valid = iv; v = (IW+1)'(vv); gama = (IW+1)'(g); beta = (IW+1)'(b);
    sq = q; isi_sel = isi; mis_sel = mis; cnt_clr = clr; rst = rs;
    s  = ref_sel(vv, g, b, q, isi, mis);
    vs = (vv > N) ? N : vv;
    if (rs) begin
      model_reset();
    end else begin
      m_ov = iv;
      if (iv) m_sv = s;
      if (clr) begin
        m_err = 1'b0;
        for (int e = 0; e < N; e++) m_cnt[e] = 0;
      end else if (iv) begin
        for (int e = 0; e < N; e++) if (s[e] && m_cnt[e] < CMAX) m_cnt[e]++;
        if (!mis && $countones(s) != vs) m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    logic [N*IW-1:0] q_rev, q_fwd, q_rnd;
    q_rev = mk_sq(5, 4, 3, 2, 1, 0);
    q_fwd = mk_sq(0, 1, 2, 3, 4, 5);
    in_valid = 0; v = 0; gama = 0; beta = 0; sq = '0;
    isi_sel = 0; mis_sel = 0; cnt_clr = 0; rst = 1;
    model_reset();

    // Reset state
    step(0, 0, 0, 0, q_fwd, 0, 0, 0, 1);
    step(0, 0, 0, 0, q_fwd, 0, 0, 0, 1);
    chk("reset_sv", 32'(sv), 32'h0);
    chk("reset_cnt", 32'(use_cnt), 32'h0);

    // Normal mode, gama/beta enables
    step(1, 3, 2, 1, q_rev, 0, 0, 0, 0);
    chk("normal_sv", 32'(sv), 32'b110001);
    chk("normal_ov", 32'(out_valid), 32'h1);
    chk("normal_err", 32'(err), 32'h0);

    // ISI bypass and mismatch-shaping bypass
    step(1, 4, 0, 0, q_fwd, 1, 0, 0, 0);
    chk("isi_sv", 32'(sv), 32'b001111);
    step(1, 2, 5, 5, mk_sq(7, 3, 3, 1, 6, 2), 1, 1, 0, 0);
    chk("mis_sv", 32'(sv), 32'b000011);

    // Count mismatch sets a sticky error
    step(1, 3, 1, 0, q_fwd, 0, 0, 0, 0);
    chk("err_onebit", 32'($countones(sv)), 32'd1);
    chk("err_set", 32'(err), 32'h1);
    for (int i = 0; i < 5; i++) step(1, 2, 2, 0, q_fwd, 0, 0, 0, 0);
    chk("err_sticky", 32'(err), 32'h1);

    // Saturation, then clear
    for (int i = 0; i < 20; i++) step(1, 6, 0, 0, q_fwd, 0, 1, 0, 0);
    for (int e = 0; e < N; e++)
      chk($sformatf("sat_cnt%0d", e), 32'(use_cnt[e*CW +: CW]), 32'd15);
    step(0, 0, 0, 0, q_fwd, 0, 0, 1, 0);
    chk("clr_cnt", 32'(use_cnt), 32'h0);
    chk("clr_err", 32'(err), 32'h0);

    // Clear alongside a valid sample: output updates, counters discarded
    step(1, 6, 0, 0, q_fwd, 0, 0, 1, 0);
    chk("clrv_sv", 32'(sv), 32'b000000);
    step(1, 2, 3, 3, q_fwd, 0, 0, 1, 0);
    chk("clrv_sv2", 32'(sv), 32'b111111);
    chk("clrv_ov", 32'(out_valid), 32'h1);
    chk("clrv_cnt", 32'(use_cnt), 32'h0);
    chk("clrv_err", 32'(err), 32'h0);

    // Reset pulse mid-stream
    step(1, 3, 2, 1, q_rev, 0, 0, 0, 0);
    step(1, 3, 2, 1, q_rev, 0, 0, 1, 1);
    chk("rst_sv", 32'(sv), 32'h0);
    chk("rst_ov", 32'(out_valid), 32'h0);
    chk("rst_cnt", 32'(use_cnt), 32'h0);
    step(1, 4, 0, 0, q_fwd, 1, 0, 0, 0);
    chk("rst_lat_sv", 32'(sv), 32'b001111);
    chk("rst_lat_ov", 32'(out_valid), 32'h1);

    // Hold with in_valid low; v above N saturates
    step(1, 3, 0, 0, q_fwd, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 5, 4, 4, q_rev, 0, 0, 0, 0);
    chk("hold_sv", 32'(sv), 32'b000111);
    chk("hold_ov", 32'(out_valid), 32'h0);
    step(1, 7, 0, 0, q_fwd, 1, 0, 0, 0);
    chk("vover_sv", 32'(sv), 32'b111111);
    chk("vover_err", 32'(err), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < N; k++) q_rnd[k*IW +: IW] = IW'($urandom_range(0, 7));
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), q_rnd,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0));
    end

    in_valid = 0; cnt_clr = 0; rst = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
